// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory bus with one outstanding transaction.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of data priority with a fetch starvation guard.
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  input  logic            flush_i,
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_wdata_i,
  input  logic [2:0]      d_size_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            spurious_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and grant a requester
  // REQ   | captured request presented on the bus, waiting for mem_gnt_i
  // RESP  | request accepted, waiting for mem_rvalid_i
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  state_t          state_q, state_d;
  owner_t          owner_q;
  logic [XLEN-1:0] adr_q, wdata_q;
  logic            we_q;
  logic [2:0]      size_q;
  logic            kill_q;
  logic            spurious_q;
  logic            fetch_wins, grant_fetch, grant_data;

`ifdef MEM_ARB_RR_EN
  logic last_fetch_q;

  // Reset value makes data win the first tie
  assign fetch_wins = if_req_i & (~d_req_i | ~last_fetch_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_fetch_q <= 1'b1;
    else if (grant_fetch || grant_data) last_fetch_q <= grant_fetch;
  end
`else
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
  logic [3:0] starve_q;

  assign fetch_wins = if_req_i & (~d_req_i | (starve_q == MAX_WAIT_L));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else if (state_q == S_IDLE) begin
      if (!if_req_i || grant_fetch) starve_q <= '0;
      else if (grant_data && starve_q != MAX_WAIT_L) starve_q <= starve_q + 4'd1;
    end
  end
`endif

  assign grant_fetch = (state_q == S_IDLE) & fetch_wins;
  assign grant_data  = (state_q == S_IDLE) & d_req_i & ~fetch_wins;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    if_gnt_o  = 1'b0;
    d_gnt_o   = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if_gnt_o = grant_fetch;
        d_gnt_o  = grant_data;
        if (grant_fetch || grant_data) state_d = S_REQ;
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      size_q     <= '0;
      kill_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (grant_fetch) begin
        owner_q <= OWN_FETCH;
        adr_q   <= if_adr_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
        size_q  <= SIZE_WORD;
        kill_q  <= 1'b0;
      end else if (grant_data) begin
        owner_q <= OWN_DATA;
        adr_q   <= d_adr_i;
        we_q    <= d_we_i;
        wdata_q <= d_wdata_i;
        size_q  <= d_size_i;
        kill_q  <= 1'b0;
      end else if (state_q == S_RESP && mem_rvalid_i) begin
        owner_q <= OWN_NONE;
      end else if (state_q != S_IDLE && owner_q == OWN_FETCH && flush_i) begin
        kill_q <= 1'b1;
      end
      if (mem_rvalid_i && state_q != S_RESP) spurious_q <= 1'b1;
    end
  end

  // A flush coinciding with the response suppresses it as well
  assign if_rvalid_o = (state_q == S_RESP) & mem_rvalid_i & (owner_q == OWN_FETCH)
                       & ~kill_q & ~flush_i;
  assign d_rvalid_o  = (state_q == S_RESP) & mem_rvalid_i & (owner_q == OWN_DATA);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i[31:0] : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

  assign mem_adr_o   = adr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign mem_size_o  = size_q;
  assign spurious_o  = spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard-driven bench for mem_arbiter: expected owner/data queued at grant, checked at response.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_i, flush_i, d_req_i, d_we_i;
  logic [31:0] if_adr_i, d_adr_i, d_wdata_i, mem_rdata_i;
  logic [2:0]  d_size_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_adr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o, spurious_o;
  logic [2:0]  mem_size_o;

  typedef struct {
    logic        fetch;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
    .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req_i = 0; flush_i = 0; d_req_i = 0; d_we_i = 0;
    if_adr_i = '0; d_adr_i = '0; d_wdata_i = '0; d_size_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    smp();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if (mem_adr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_adr: got %h want 0", mem_adr_o); end
    n_checks++; if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o} !== 4'b0) begin n_fail++; $display("FAIL rst_gnt_rvalid: got %b want 0000", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}); end
    n_checks++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL rst_spurious: got %b want 0", spurious_o); end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_fetch_basic();
    exp_t e;
    step();
    if_req_i = 1; if_adr_i = 32'h8000_0000;
    smp();
    n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fb_if_gnt: got %b want 1", if_gnt_o); end
    n_checks++; if (d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL fb_d_gnt: got %b want 0", d_gnt_o); end
    sb_q.push_back('{fetch: 1'b1, data: 32'h0000_0013});
    step();
    if_req_i = 0; mem_gnt_i = 1;
    smp();
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL fb_mem_req: got %b want 1", mem_req_o); end
    n_checks++; if (mem_adr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL fb_mem_adr: got %h want 80000000", mem_adr_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL fb_mem_we: got %b want 0", mem_we_o); end
    n_checks++; if (mem_size_o !== 3'b010) begin n_fail++; $display("FAIL fb_mem_size: got %b want 010", mem_size_o); end
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    smp();
    n_checks++; if (if_rvalid_o !== 1'b1 || sb_q.size() == 0) begin n_fail++; $display("FAIL fb_if_rvalid: got %b want 1", if_rvalid_o); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (if_rdata_o !== e.data) begin n_fail++; $display("FAIL fb_if_rdata: got %h want %h", if_rdata_o, e.data); end
    end
    n_checks++; if (d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fb_d_rvalid: got %b want 0", d_rvalid_o); end
    step();
    mem_rvalid_i = 0;
  endtask

  task automatic test_priority();
    exp_t e;
    step();
    if_req_i = 1; if_adr_i = 32'h8000_0004;
    d_req_i = 1; d_adr_i = 32'h0000_1000; d_we_i = 1; d_wdata_i = 32'hDEAD_BEEF; d_size_i = 3'b010;
    smp();
    n_checks++; if ({d_gnt_o, if_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL pr_first_gnt: got d/if=%b want 10", {d_gnt_o, if_gnt_o}); end
    sb_q.push_back('{fetch: 1'b0, data: 32'h0});
    step();
    d_req_i = 0; mem_gnt_i = 1;
    smp();
    n_checks++; if ({mem_req_o, mem_we_o} !== 2'b11) begin n_fail++; $display("FAIL pr_mem_req_we: got %b want 11", {mem_req_o, mem_we_o}); end
    n_checks++; if (mem_wdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pr_mem_wdata: got %h want deadbeef", mem_wdata_o); end
    n_checks++; if (mem_adr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL pr_mem_adr: got %h want 00001000", mem_adr_o); end
    n_checks++; if (if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL pr_no_gnt_busy: got %b want 0", if_gnt_o); end
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
    smp();
    n_checks++; if (sb_q.size() == 0 || {if_rvalid_o, d_rvalid_o} !== {sb_q[0].fetch, ~sb_q[0].fetch}) begin n_fail++; $display("FAIL pr_store_ack: got if/d=%b want 01", {if_rvalid_o, d_rvalid_o}); end
    if (sb_q.size() != 0) e = sb_q.pop_front();
    step();
    mem_rvalid_i = 0;
    smp();
    n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL pr_fetch_next: got %b want 1", if_gnt_o); end
    sb_q.push_back('{fetch: 1'b1, data: 32'h0010_0093});
    step();
    if_req_i = 0; mem_gnt_i = 1;
    smp();
    n_checks++; if (mem_adr_o !== 32'h8000_0004 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL pr_fetch_bus: got adr=%h we=%b want 80000004/0", mem_adr_o, mem_we_o); end
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0010_0093;
    smp();
    n_checks++; if (if_rvalid_o !== 1'b1 || sb_q.size() == 0) begin n_fail++; $display("FAIL pr_fetch_rvalid: got %b want 1", if_rvalid_o); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (if_rdata_o !== e.data) begin n_fail++; $display("FAIL pr_fetch_rdata: got %h want %h", if_rdata_o, e.data); end
    end
    step();
    mem_rvalid_i = 0;
  endtask

  task automatic test_starvation();
`ifdef MEM_ARB_RR_EN
    logic [5:0] exp_f = 6'b101010;
`else
    logic [5:0] exp_f = 6'b010000;
`endif
    step();
    if_req_i = 1; d_req_i = 1; d_we_i = 0; d_size_i = 3'b000;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [31:0] rd;
      if_adr_i = 32'h8000_1000 + 32'(i * 4);
      d_adr_i  = 32'h0000_2000 + 32'(i * 4);
      rd = 32'hC000_0000 + 32'(i);
      smp();
      n_checks++; if ((if_gnt_o ^ d_gnt_o) !== 1'b1) begin n_fail++; $display("FAIL st_one_gnt[%0d]: got if/d=%b want one-hot", i, {if_gnt_o, d_gnt_o}); end
      n_checks++; if (if_gnt_o !== exp_f[i]) begin n_fail++; $display("FAIL st_winner[%0d]: got fetch=%b want %b", i, if_gnt_o, exp_f[i]); end
      sb_q.push_back('{fetch: exp_f[i], data: rd});
      step();
      mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd;
      smp();
      if (sb_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL st_sb_empty[%0d]: got empty want entry", i); end
      else begin
        e = sb_q.pop_front();
        n_checks++; if ({if_rvalid_o, d_rvalid_o} !== {e.fetch, ~e.fetch}) begin n_fail++; $display("FAIL st_route[%0d]: got if/d=%b want %b", i, {if_rvalid_o, d_rvalid_o}, {e.fetch, ~e.fetch}); end
        n_checks++; if ((e.fetch ? if_rdata_o : d_rdata_o) !== e.data) begin n_fail++; $display("FAIL st_rdata[%0d]: got %h want %h", i, (e.fetch ? if_rdata_o : d_rdata_o), e.data); end
      end
      step();
      mem_rvalid_i = 0;
      if (i == 5) begin if_req_i = 0; d_req_i = 0; end
    end
  endtask

  task automatic test_gnt_wait();
    exp_t e;
    step();
    d_req_i = 1; d_adr_i = 32'h0000_3000; d_we_i = 1; d_wdata_i = 32'h1234_5678; d_size_i = 3'b001;
    smp();
    n_checks++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL gw_d_gnt: got %b want 1", d_gnt_o); end
    sb_q.push_back('{fetch: 1'b0, data: 32'h0});
    step();
    d_req_i = 0; d_adr_i = 32'hFFFF_0000; d_wdata_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      smp();
      n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL gw_req_hold[%0d]: got %b want 1", i, mem_req_o); end
      n_checks++; if (mem_adr_o !== 32'h0000_3000 || mem_wdata_o !== 32'h1234_5678 || mem_size_o !== 3'b001) begin n_fail++; $display("FAIL gw_stable[%0d]: got adr=%h wd=%h sz=%b want 00003000/12345678/001", i, mem_adr_o, mem_wdata_o, mem_size_o); end
      step();
    end
    mem_gnt_i = 1;
    smp();
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL gw_req_at_gnt: got %b want 1", mem_req_o); end
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    smp();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL gw_req_drop: got %b want 0", mem_req_o); end
    n_checks++; if (sb_q.size() == 0 || d_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL gw_d_rvalid: got %b want 1", d_rvalid_o); end
    if (sb_q.size() != 0) e = sb_q.pop_front();
    step();
    mem_rvalid_i = 0;
  endtask

  task automatic test_flush();
    exp_t e;
    // Flush pulsed in RESP before the response arrives
    step();
    if_req_i = 1; if_adr_i = 32'h8000_0100;
    smp();
    n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fl_gnt1: got %b want 1", if_gnt_o); end
    step();
    if_req_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; flush_i = 1;
    step();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_F00D;
    smp();
    n_checks++; if (if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fl_killed: got %b want 0", if_rvalid_o); end
    step();
    mem_rvalid_i = 0;
    // Flush coincident with the response
    if_req_i = 1; if_adr_i = 32'h8000_0180;
    smp();
    n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fl_gnt2: got %b want 1", if_gnt_o); end
    step();
    if_req_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; flush_i = 1; mem_rdata_i = 32'h0BAD_F00E;
    smp();
    n_checks++; if (if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fl_same_cycle: got %b want 0", if_rvalid_o); end
    step();
    mem_rvalid_i = 0; flush_i = 0;
    // Next fetch is served normally
    if_req_i = 1; if_adr_i = 32'h8000_0200;
    smp();
    n_checks++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fl_gnt3: got %b want 1", if_gnt_o); end
    sb_q.push_back('{fetch: 1'b1, data: 32'h0000_0073});
    step();
    if_req_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0073;
    smp();
    n_checks++; if (if_rvalid_o !== 1'b1 || sb_q.size() == 0) begin n_fail++; $display("FAIL fl_next_rvalid: got %b want 1", if_rvalid_o); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (if_rdata_o !== e.data) begin n_fail++; $display("FAIL fl_next_rdata: got %h want %h", if_rdata_o, e.data); end
    end
    n_checks++; if (spurious_o !== 1'b0) begin n_fail++; $display("FAIL fl_no_spurious: got %b want 0", spurious_o); end
    step();
    mem_rvalid_i = 0;
  endtask

  task automatic test_reset_mid();
    step();
    if_req_i = 1; if_adr_i = 32'h8000_0300;
    step();
    if_req_i = 0; mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; reset_n = 0;
    smp();
    n_checks++; if ({mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, spurious_o} !== 6'b0) begin n_fail++; $display("FAIL rm_outputs: got %b want 000000", {mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, spurious_o}); end
    n_checks++; if (mem_adr_o !== 32'h0) begin n_fail++; $display("FAIL rm_mem_adr: got %h want 0", mem_adr_o); end
    step();
    reset_n = 1;
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
    smp();
    n_checks++; if ({if_rvalid_o, d_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rm_no_rvalid: got %b want 00", {if_rvalid_o, d_rvalid_o}); end
    step();
    mem_rvalid_i = 0;
    smp();
    n_checks++; if (spurious_o !== 1'b1) begin n_fail++; $display("FAIL rm_spurious: got %b want 1", spurious_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_basic();
    test_priority();
    test_starvation();
    test_gnt_wait();
    test_flush();
    test_reset_mid();
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
